// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Definitions shared by the fetch stage and the decode/immediate logic
// downstream of it:
//   - major opcode values for the R/I/L/S/B instruction formats
//   - the canonical NOP word (addi x0, x0, 0)
//   - the state encoding of the fetch controller
//   - a helper that tells whether a byte address is word aligned
// ---------------------------------------------------------------------------
package riscv_pkg;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
   localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Fetch controller states
   localparam logic [1:0] FETCH_ST = 2'd0;  // issue a request for pc
   localparam logic [1:0] WAIT_ST  = 2'd1;  // request outstanding
   localparam logic [1:0] HOLD_ST  = 2'd2;  // word presented to decode

   // A redirect target is usable only when it lands on a 4-byte boundary.
   function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb == 2'b00);
   endfunction

endpackage : riscv_pkg

// File: rtl/pc_register.sv
// ---------------------------------------------------------------------------
// pc_register
// Holds the fetch program counter. A load (redirect) has priority over a
// sequential increment. The increment adds 4 modulo 2^XLEN, so the top
// word address wraps to zero without any error indication.
//
// Ports:
//   clk       in   clock, all updates on the rising edge
//   rst       in   synchronous active-high reset, loads RESET_PC
//   load_en   in   load load_val into pc
//   load_val  in   XLEN-bit value to load (redirect target)
//   inc_en    in   advance pc by 4 (ignored when load_en is set)
//   pc        out  current program counter
// ---------------------------------------------------------------------------
module pc_register #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [XLEN-1:0]   load_val,
   input  logic              inc_en,
   output logic [XLEN-1:0]   pc
);

   logic [XLEN-1:0] pc_inc_s;

   // Next sequential pc; natural overflow gives the modulo wrap.
   assign pc_inc_s = pc + {{(XLEN-3){1'b0}}, 3'b100};

   // PC register: reset, then redirect load, then sequential increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (load_en) begin
         pc <= load_val;
      end else if (inc_en) begin
         pc <= pc_inc_s;
      end else begin
         pc <= pc;
      end
   end

endmodule : pc_register

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// Fetch stage feeding decode. Issues at most one instruction-memory request
// at a time, registers the returned word and hands it to decode over a
// valid/ready handshake. Branch redirects from downstream move the pc and
// squash any wrong-path word still in flight (via the kill flag).
//
// Ports:
//   clk             in   clock
//   rst             in   synchronous active-high reset
//   imem_req        out  one-cycle request pulse
//   imem_addr       out  address of the request (held between requests)
//   imem_rvalid     in   read data valid, only honoured in WAIT
//   imem_rdata      in   returned instruction word
//   instr           out  instruction presented to decode
//   instr_pc        out  pc of instr
//   instr_valid     out  instr/instr_pc valid
//   instr_ready     in   decode can accept
//   branch_taken    in   single-cycle redirect request
//   branch_target   in   redirect pc
//   misaligned_err  out  one-cycle pulse for a redirect with target[1:0]!=0
// ---------------------------------------------------------------------------
module instruction_fetch
   import riscv_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr,
   output logic [XLEN-1:0]   instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              branch_taken,
   input  logic [XLEN-1:0]   branch_target,
   output logic              misaligned_err
);

   logic [1:0]        state_r;
   logic              kill_r;
   logic [XLEN-1:0]   pc_s;

   logic [1:0]        state_nxt_s;
   logic              kill_nxt_s;
   logic              req_nxt_s;
   logic [XLEN-1:0]   addr_nxt_s;
   logic [31:0]       instr_nxt_s;
   logic [XLEN-1:0]   instr_pc_nxt_s;
   logic              valid_nxt_s;
   logic              mis_nxt_s;
   logic              pc_load_s;
   logic              pc_inc_s;
   logic              target_ok_s;
   logic              redirect_s;

   // A misaligned target is reported but otherwise treated as no redirect.
   assign target_ok_s = is_word_aligned(branch_target[1:0]);
   assign redirect_s  = branch_taken & target_ok_s;

   pc_register #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk      (clk),
      .rst      (rst),
      .load_en  (pc_load_s),
      .load_val (branch_target),
      .inc_en   (pc_inc_s),
      .pc       (pc_s)
   );

   // Next-state and next-output logic of the fetch controller.
   always_comb begin
      state_nxt_s    = state_r;
      kill_nxt_s     = kill_r;
      req_nxt_s      = 1'b0;
      addr_nxt_s     = imem_addr;
      instr_nxt_s    = instr;
      instr_pc_nxt_s = instr_pc;
      valid_nxt_s    = instr_valid;
      mis_nxt_s      = branch_taken & ~target_ok_s;
      pc_load_s      = 1'b0;
      pc_inc_s       = 1'b0;

      case (state_r)
         FETCH_ST: begin
            // The request for the current pc always goes out; a redirect
            // arriving now marks that request as wrong-path.
            req_nxt_s   = 1'b1;
            addr_nxt_s  = pc_s;
            state_nxt_s = WAIT_ST;
            if (redirect_s) begin
               pc_load_s  = 1'b1;
               kill_nxt_s = 1'b1;
            end else begin
               kill_nxt_s = kill_r;
            end
         end

         WAIT_ST: begin
            if (imem_rvalid) begin
               if (redirect_s) begin
                  // Returned word is wrong-path; refetch from the target.
                  pc_load_s   = 1'b1;
                  kill_nxt_s  = 1'b0;
                  state_nxt_s = FETCH_ST;
               end else if (kill_r) begin
                  // Squashed word; pc already holds the redirect target.
                  kill_nxt_s  = 1'b0;
                  state_nxt_s = FETCH_ST;
               end else begin
                  instr_nxt_s    = imem_rdata;
                  instr_pc_nxt_s = pc_s;
                  valid_nxt_s    = 1'b1;
                  state_nxt_s    = HOLD_ST;
               end
            end else if (redirect_s) begin
               // Data still in flight: remember to drop it when it lands.
               pc_load_s  = 1'b1;
               kill_nxt_s = 1'b1;
            end else begin
               state_nxt_s = WAIT_ST;
            end
         end

         HOLD_ST: begin
            // Any branch_taken (even misaligned) blocks the transfer.
            if (redirect_s) begin
               valid_nxt_s = 1'b0;
               pc_load_s   = 1'b1;
               state_nxt_s = FETCH_ST;
            end else if (instr_valid & instr_ready & ~branch_taken) begin
               valid_nxt_s = 1'b0;
               pc_inc_s    = 1'b1;
               state_nxt_s = FETCH_ST;
            end else begin
               state_nxt_s = HOLD_ST;
            end
         end

         default: begin
            // Unused encoding: recover to a clean fetch.
            state_nxt_s = FETCH_ST;
            kill_nxt_s  = 1'b0;
            valid_nxt_s = 1'b0;
         end
      endcase
   end

   // Controller state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= FETCH_ST;
         kill_r         <= 1'b0;
         imem_req       <= 1'b0;
         imem_addr      <= RESET_PC;
         instr          <= NOP_INSTR;
         instr_pc       <= RESET_PC;
         instr_valid    <= 1'b0;
         misaligned_err <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         kill_r         <= kill_nxt_s;
         imem_req       <= req_nxt_s;
         imem_addr      <= addr_nxt_s;
         instr          <= instr_nxt_s;
         instr_pc       <= instr_pc_nxt_s;
         instr_valid    <= valid_nxt_s;
         misaligned_err <= mis_nxt_s;
      end
   end

endmodule : instruction_fetch

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of decode and immediate generation.
- Owns the PC and issues one instruction-memory request at a time.
- Registers the returned word and hands it to decode over a valid/ready handshake; decode's immediate generator consumes `instr`.
- Accepts branch redirects (target = PC + B-immediate, computed downstream) and squashes wrong-path fetches.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  one-cycle request pulse; address valid in the same cycle.
- imem_addr  out  XLEN  word address of the request.
- imem_rvalid  in  1  read data valid; at least 1 cycle after imem_req.
- imem_rdata  in  32  instruction word, sampled when imem_rvalid=1.
- instr  out  32  fetched instruction presented to decode.
- instr_pc  out  XLEN  PC of `instr`.
- instr_valid  out  1  `instr`/`instr_pc` valid.
- instr_ready  in  1  decode can accept.
- branch_taken  in  1  redirect request, single cycle.
- branch_target  in  XLEN  redirect PC.
- misaligned_err  out  1  one-cycle pulse when a redirect target has target[1:0]!=0.

Behaviour:
- Reset (rst=1 at clock edge):
  - pc=RESET_PC, state=FETCH, kill=0.
  - imem_req=0, imem_addr=RESET_PC.
  - instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_valid=0, misaligned_err=0.
  - Reset mid-operation abandons any outstanding request; a late imem_rvalid after reset is ignored while kill is clear and state is FETCH.
- All outputs are registered. The first imem_req occurs in the first cycle after rst deasserts.
- States:
  - FETCH: drive imem_req=1, imem_addr=pc; next state WAIT.
  - WAIT: on imem_rvalid:
    - kill=0: capture instr<=imem_rdata, instr_pc<=pc, instr_valid<=1; go HOLD.
    - kill=1: discard data, clear kill; go FETCH (pc already holds redirect target).
  - HOLD: instr_valid=1.
    - Transfer occurs iff instr_valid & instr_ready & ~branch_taken.
    - On transfer: pc<=pc+4, instr_valid<=0; go FETCH.
- One outstanding request maximum; no request is issued while in WAIT or HOLD.
- Redirect (branch_taken=1, branch_target[1:0]==0):
  - In FETCH: the request is issued this cycle; pc<=branch_target, kill<=1; go WAIT.
  - In WAIT, no rvalid: pc<=branch_target, kill<=1; stay WAIT.
  - In WAIT, rvalid the same cycle: data discarded, pc<=branch_target, kill<=0; go FETCH.
  - In HOLD: instr_valid<=0, pc<=branch_target; go FETCH. Redirect wins over a simultaneous instr_ready; no transfer occurs.
- Misaligned redirect (branch_target[1:0]!=0): misaligned_err=1 for one cycle; redirect ignored; state, pc and kill unchanged.
- PC arithmetic is modulo 2^XLEN: pc+4 wraps 32'hFFFF_FFFC to 32'h0000_0000 with no error.
- instr and instr_pc are stable while instr_valid=1 and no transfer or redirect has occurred.
- imem_rvalid outside WAIT is ignored.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode localparams (R/I/L/S/B types);
  - NOP_INSTR=32'h0000_0013;
  - fetch state encoding (FETCH, WAIT, HOLD).
- RESET_PC stays a module parameter.
- Sub-module pc_register:
  - holds pc;
  - inputs: load_en, load_val, inc_en;
  - synchronous reset to RESET_PC;
  - supplies pc+4 internally.
- FSM, kill flag and output registers stay in instruction_fetch.

Test Plan:
- Reset then memory with 1-cycle latency, instr_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; instr_pc matches; instr_valid pulses once per fetch; instr=NOP during reset.
- Decode stalls (instr_ready=0 for 5 cycles) in HOLD at pc=0x8 -> instr and instr_pc held constant; no imem_req; transfer on first ready cycle; next imem_addr=0xC.
- branch_taken, target=0x40, while in WAIT with 3-cycle latency -> returned word discarded; instr_valid stays 0; next imem_addr=0x40; delivered instr_pc=0x40.
- branch_taken, target=0x100, in HOLD with instr_ready=1 the same cycle -> no transfer; instr_valid drops; next imem_addr=0x100.
- branch_taken, target=0x102 -> misaligned_err pulses one cycle; fetch continues sequentially from current pc.
- RESET_PC=32'hFFFF_FFFC -> first fetch 0xFFFF_FFFC, then 0x0000_0000; rst asserted during WAIT -> next imem_addr=RESET_PC; late rvalid ignored.
